// File: rtl/led_ctrl.sv
// -----------------------------------------------------------------------------
// led_ctrl : four-channel LED driver peripheral with a small register bus.
//
// Each LED is either driven directly from a CTRL bit or by a shared 8-bit PWM
// counter compared against a per-LED duty byte. The PWM counter advances on a
// prescaler tick generated every PRESC+1 clock cycles.
//
// Register map (byte offsets, only addr[3:2] decoded):
//   0x0 CTRL   [3:0] direct LED value, [7:4] per-LED mode (1 = PWM)
//   0x4 DUTY   byte i = duty of LED i
//   0x8 PRESC  [PRESC_W-1:0] prescaler reload value
//   0xC STATUS [7:0] pwm_cnt, [8] sticky wrap flag (any write clears it)
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous active-high reset
//   sel    - one-cycle bus access strobe
//   we     - write enable, qualified by sel
//   addr   - byte address
//   wdata  - write data
//   rdata  - registered read data, holds between reads
//   led    - registered LED drive
//
// PRESC_W is expected to lie in 1..32.
// -----------------------------------------------------------------------------
module led_ctrl #(
  parameter int PRESC_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [3:0]  led
);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_DUTY   = 2'd1;
  localparam logic [1:0] A_PRESC  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic [7:0]         ctrl_q,    ctrl_d;
  logic [31:0]        duty_q,    duty_d;
  logic [PRESC_W-1:0] presc_q,   presc_d;
  logic [PRESC_W-1:0] pcnt_q,    pcnt_d;
  logic [7:0]         pwm_cnt_q, pwm_cnt_d;
  logic               wrap_q,    wrap_d;
  logic [31:0]        rdata_q,   rdata_d;
  logic [3:0]         led_q,     led_d;

  logic               wr_en;
  logic               rd_en;
  logic               tick;
  logic [31:0]        presc_rd;
  logic [31:0]        rd_mux;

  // Byte-lane bits of the address are never decoded.
  logic               unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  // Bus strobes: we/addr/wdata only matter while sel is high.
  always_comb begin
    wr_en = sel & we;
    rd_en = sel & ~we;
  end

  // Prescaler countdown, tick generation, PWM counter and wrap flag.
  always_comb begin
    tick   = 1'b0;
    pcnt_d = pcnt_q;
    if (wr_en && (addr[3:2] == A_PRESC)) begin
      // Reloading from the bus restarts the period; suppress this cycle's tick.
      pcnt_d = wdata[PRESC_W-1:0];
    end else if (pcnt_q == {PRESC_W{1'b0}}) begin
      tick   = 1'b1;
      pcnt_d = presc_q;
    end else begin
      pcnt_d = pcnt_q - PRESC_W'(1);
    end

    if (tick) begin
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end else begin
      pwm_cnt_d = pwm_cnt_q;
    end

    // Setting on wrap outranks a coincident clear so no wrap event is lost.
    if (tick && (pwm_cnt_q == 8'hFF)) begin
      wrap_d = 1'b1;
    end else if (wr_en && (addr[3:2] == A_STATUS)) begin
      wrap_d = 1'b0;
    end else begin
      wrap_d = wrap_q;
    end
  end

  // Register file writes.
  always_comb begin
    ctrl_d  = ctrl_q;
    duty_d  = duty_q;
    presc_d = presc_q;
    if (wr_en) begin
      case (addr[3:2])
        A_CTRL:   ctrl_d  = wdata[7:0];
        A_DUTY:   duty_d  = wdata;
        A_PRESC:  presc_d = wdata[PRESC_W-1:0];
        A_STATUS: ctrl_d  = ctrl_q;  // only affects the wrap flag
        default:  ctrl_d  = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Read mux over pre-edge register values; rdata holds when no read.
  always_comb begin
    presc_rd                = 32'h0000_0000;
    presc_rd[PRESC_W-1:0]   = presc_q;
    case (addr[3:2])
      A_CTRL:   rd_mux = {24'h00_0000, ctrl_q};
      A_DUTY:   rd_mux = duty_q;
      A_PRESC:  rd_mux = presc_rd;
      A_STATUS: rd_mux = {23'h00_0000, wrap_q, pwm_cnt_q};
      default:  rd_mux = 32'h0000_0000;
    endcase
    if (rd_en) begin
      rdata_d = rd_mux;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // LED selection between direct bit and PWM comparison.
  always_comb begin
    led_d = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (ctrl_q[4+i]) begin
        led_d[i] = (pwm_cnt_q < duty_q[8*i +: 8]);
      end else begin
        led_d[i] = ctrl_q[i];
      end
    end
  end

  // State registers with synchronous reset taking priority over the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= 8'h00;
      duty_q    <= 32'h0000_0000;
      presc_q   <= {PRESC_W{1'b0}};
      pcnt_q    <= {PRESC_W{1'b0}};
      pwm_cnt_q <= 8'h00;
      wrap_q    <= 1'b0;
      rdata_q   <= 32'h0000_0000;
      led_q     <= 4'h0;
    end else begin
      ctrl_q    <= ctrl_d;
      duty_q    <= duty_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      wrap_q    <= wrap_d;
      rdata_q   <= rdata_d;
      led_q     <= led_d;
    end
  end

  assign rdata = rdata_q;
  assign led   = led_q;

endmodule

// File: tb/tb_led_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_ctrl : self-checking bench for led_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge. Expected
// read data is pushed to exp_q when a read is issued and popped when rdata
// appears one edge later. The PWM counter is predicted from the edge count
// since the last reset / PRESC write.
// -----------------------------------------------------------------------------
module tb_led_ctrl;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  led;

  led_ctrl #(.PRESC_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_q[$];

  // Reference point for the PWM counter prediction.
  int ref_edge  = 0;
  int ref_pwm   = 0;
  int ref_presc = 0;
  int ref_c     = 0;

  // Predicted pwm_cnt d edges from now (value seen before that edge).
  function automatic int exp_pwm_at(input int d);
    int j;
    j = edge_n + d - ref_edge;
    return (ref_pwm + (j + ref_presc - ref_c) / (ref_presc + 1)) % 256;
  endfunction

  function automatic logic [31:0] status_w(input logic w);
    logic [7:0] p;
    p = 8'(exp_pwm_at(0));
    return {23'h0, w, p};
  endfunction

  task automatic do_reset();
    reset = 1'b1; sel = 1'b0; we = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    ref_edge  = edge_n;
    ref_pwm   = 0;
    ref_presc = 0;
    ref_c     = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    int cur;
    cur = exp_pwm_at(0);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; wdata = 32'h0;
    if (a[3:2] == 2'b10) begin
      ref_pwm   = cur;
      ref_edge  = edge_n;
      ref_presc = int'(d[15:0]);
      ref_c     = ref_presc;
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    do_reset();
    checks++;
    if (led !== 4'h0) begin fails++; $display("FAIL reset_led: got %h expected %h", led, 4'h0); end
    checks++;
    if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
    for (int i = 0; i < 4; i++) begin
      rd(4'(i * 4), (i == 3) ? status_w(1'b0) : 32'h0);
      e = exp_q.pop_front();
      checks++;
      if (rdata !== e) begin fails++; $display("FAIL reset_reg%0d: got %h expected %h", i, rdata, e); end
    end
  endtask

  task automatic test_direct();
    logic [31:0] e;
    do_reset();
    wr(4'h0, 32'h0000_0005);
    checks++;
    if (led !== 4'h0) begin fails++; $display("FAIL direct_same_edge: got %h expected %h", led, 4'h0); end
    @(negedge clk);
    checks++;
    if (led !== 4'h5) begin fails++; $display("FAIL direct_led: got %h expected %h", led, 4'h5); end
    rd(4'h0, 32'h0000_0005);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin fails++; $display("FAIL direct_read: got %h expected %h", rdata, e); end
  endtask

  task automatic test_pwm();
    int cnt[4];
    logic [31:0] e;
    do_reset();
    wr(4'h8, 32'h0);
    wr(4'h4, 32'h00FF_8040);
    wr(4'h0, 32'h0000_00F0);
    repeat (2) @(negedge clk);
    exp_q.push_back(32'd64);
    exp_q.push_back(32'd128);
    exp_q.push_back(32'd255);
    exp_q.push_back(32'd0);
    for (int b = 0; b < 4; b++) cnt[b] = 0;
    for (int k = 0; k < 256; k++) begin
      for (int b = 0; b < 4; b++) cnt[b] += int'(led[b]);
      @(negedge clk);
    end
    for (int b = 0; b < 4; b++) begin
      e = exp_q.pop_front();
      checks++;
      if (32'(cnt[b]) !== e) begin fails++; $display("FAIL pwm_led%0d_count: got %0d expected %0d", b, cnt[b], e); end
    end
  endtask

  task automatic test_prescaler();
    logic [31:0] e;
    do_reset();
    wr(4'h8, 32'h3);
    sel = 1'b1; we = 1'b0; addr = 4'hC;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(status_w(1'b0));
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (rdata !== e) begin fails++; $display("FAIL presc_step%0d: got %h expected %h", i, rdata, e); end
    end
    sel = 1'b0;
    @(negedge clk);
    // This rewrite lands on what would have been a tick edge.
    wr(4'h8, 32'h3);
    sel = 1'b1; we = 1'b0; addr = 4'hC;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(status_w(1'b0));
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (rdata !== e) begin fails++; $display("FAIL presc_rewrite%0d: got %h expected %h", i, rdata, e); end
    end
    sel = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    int n;
    do_reset();
    wr(4'h8, 32'h0);
    repeat (260) @(negedge clk);
    rd(4'hC, status_w(1'b1));
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin fails++; $display("FAIL wrap_set: got %h expected %h", rdata, e); end
    wr(4'hC, 32'h0);
    rd(4'hC, status_w(1'b0));
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin fails++; $display("FAIL wrap_clear: got %h expected %h", rdata, e); end
    n = 0;
    while (exp_pwm_at(0) != 255 && n < 600) begin @(negedge clk); n++; end
    if (n >= 600) begin fails++; $display("FAIL wrap_wait: got timeout expected pwm 255"); end
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'hC, status_w(1'b1));
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin fails++; $display("FAIL wrap_set_wins: got %h expected %h", rdata, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    int n;
    do_reset();
    wr(4'h8, 32'h2);
    wr(4'h4, 32'h8080_8080);
    wr(4'h0, 32'h0000_00FF);
    n = 0;
    while (exp_pwm_at(0) != 100 && n < 600) begin @(negedge clk); n++; end
    if (n >= 600) begin fails++; $display("FAIL rmid_wait: got timeout expected pwm 100"); end
    rd(4'hC, status_w(1'b0));
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin fails++; $display("FAIL rmid_status: got %h expected %h", rdata, e); end
    checks++;
    if (led !== 4'hF) begin fails++; $display("FAIL rmid_led_before: got %h expected %h", led, 4'hF); end
    do_reset();
    checks++;
    if (led !== 4'h0) begin fails++; $display("FAIL rmid_led: got %h expected %h", led, 4'h0); end
    checks++;
    if (rdata !== 32'h0) begin fails++; $display("FAIL rmid_rdata: got %h expected %h", rdata, 32'h0); end
    sel = 1'b1; we = 1'b0; addr = 4'hC;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({23'h0, 1'b0, 8'(i)});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (rdata !== e) begin fails++; $display("FAIL rmid_count%0d: got %h expected %h", i, rdata, e); end
    end
    sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd(4'(i * 4), 32'h0);
      e = exp_q.pop_front();
      checks++;
      if (rdata !== e) begin fails++; $display("FAIL rmid_reg%0d: got %h expected %h", i, rdata, e); end
    end
  endtask

  task automatic test_bus_corners();
    logic [31:0] e;
    int n;
    do_reset();
    wr(4'h8, 32'h3);
    n = 0;
    while (exp_pwm_at(1) == exp_pwm_at(0) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin fails++; $display("FAIL corner_tick_wait: got timeout expected tick"); end
    rd(4'hC, status_w(1'b0));
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin fails++; $display("FAIL corner_read_on_tick: got %h expected %h", rdata, e); end

    wr(4'h0, 32'hFFFF_FFFF);
    rd(4'h0, 32'h0000_00FF);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin fails++; $display("FAIL corner_ctrl_mask: got %h expected %h", rdata, e); end
    exp_q.push_back(32'h0000_00FF);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin fails++; $display("FAIL corner_rdata_hold: got %h expected %h", rdata, e); end

    wr(4'h4, 32'h1234_5678);
    sel = 1'b0; we = 1'b1; wdata = 32'hA5A5_A5A5;
    for (int i = 0; i < 4; i++) begin
      addr = 4'(i * 4);
      @(negedge clk);
    end
    we = 1'b0; wdata = 32'h0;
    rd(4'h0, 32'h0000_00FF);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin fails++; $display("FAIL corner_nosel_ctrl: got %h expected %h", rdata, e); end
    rd(4'h4, 32'h1234_5678);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin fails++; $display("FAIL corner_nosel_duty: got %h expected %h", rdata, e); end
    rd(4'h8, 32'h0000_0003);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin fails++; $display("FAIL corner_nosel_presc: got %h expected %h", rdata, e); end
    rd(4'hC, status_w(1'b0));
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin fails++; $display("FAIL corner_nosel_status: got %h expected %h", rdata, e); end

    wr(4'h8, 32'hFFFF_FFFF);
    rd(4'h8, 32'h0000_FFFF);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin fails++; $display("FAIL corner_presc_mask: got %h expected %h", rdata, e); end
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 4'h0; wdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_direct();
    test_pwm();
    test_prescaler();
    test_wrap();
    test_reset_mid();
    test_bus_corners();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_ctrl.md
LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 The block SHALL have parameter PRESC_W, default 16, meaning width of the prescaler register and counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port sel, input, 1 bit: bus access strobe for this peripheral, valid for one cycle per access.
REQ-005 The block SHALL have port we, input, 1 bit: write enable, qualified by sel.
REQ-006 The block SHALL have port addr, input, 4 bits: byte address; only addr[3:2] SHALL be decoded.
REQ-007 The block SHALL have port wdata, input, 32 bits: write data.
REQ-008 The block SHALL have port rdata, output, 32 bits: registered read data.
REQ-009 The block SHALL have port led, output, 4 bits: registered LED drive to the board pins.

Function
REQ-010 Register 0x0 CTRL SHALL be read/write: bits[3:0] are the direct LED values; bits[7:4] are per-LED mode (0 = direct, 1 = PWM); bits[31:8] SHALL be ignored on write and read as 0.
REQ-011 Register 0x4 DUTY SHALL be read/write: LED i duty is bits[8i+7:8i].
REQ-012 Register 0x8 PRESC SHALL be read/write: bits[PRESC_W-1:0] hold the prescaler reload value; upper bits SHALL read as 0.
REQ-013 Register 0xC STATUS SHALL return bits[7:0] = current pwm_cnt and bit 8 = sticky wrap flag, with the other bits reading 0; any write to STATUS SHALL clear the wrap flag.
REQ-014 A write SHALL take effect at the rising edge where sel=1 and we=1.
REQ-015 A read (sel=1, we=0) SHALL load rdata at that edge with the register value as it stood before the edge; rdata SHALL hold its value when no read occurs.
REQ-016 The prescaler counter SHALL decrement each cycle; when it equals 0, it SHALL assert tick for that cycle and reload from PRESC, so a tick occurs every PRESC+1 cycles. PRESC=0 SHALL give a tick every cycle.
REQ-017 A write to PRESC SHALL also load the prescaler counter with the new value at the same edge, and no tick SHALL occur in that cycle.
REQ-018 On tick, the 8-bit pwm_cnt SHALL increment modulo 256.
REQ-019 When pwm_cnt goes from 255 to 0, the wrap flag SHALL be set; if a STATUS write coincides with a wrap, the set SHALL win.
REQ-020 The PWM level for LED i SHALL be (pwm_cnt < duty_i), unsigned: duty 0 SHALL always give 0, and duty 255 SHALL give 1 for 255 of 256 counts.
REQ-021 Each edge SHALL set led[i] to the PWM level if mode_i=1, otherwise to direct_i, using the register values before that edge; a CTRL write at edge N SHALL therefore appear on led at edge N+1.
REQ-022 Unused address space SHALL not exist: all four offsets are decoded.
REQ-023 When sel=0, the we, addr and wdata inputs SHALL be ignored.

Reset
REQ-024 While reset=1 at a rising edge, the following SHALL all be set to 0: CTRL, DUTY, PRESC, prescaler counter, pwm_cnt, wrap flag, rdata and led.
REQ-025 Reset SHALL take priority over any simultaneous bus access.
REQ-026 Reset asserted mid-PWM-period SHALL abandon the period, and counting SHALL restart from 0 on the first edge after reset is released.
REQ-027 After reset, PRESC=0, so pwm_cnt SHALL advance every cycle.

Verification
REQ-028 Direct mode: reset, write CTRL=0x0000_0005 -> led=4'b0101 from the next edge; read CTRL returns 0x0000_0005.
REQ-029 PWM duty: write PRESC=0, DUTY=0x00FF_8040, CTRL=0xF0 -> over 256 consecutive cycles, led[0]=1 for 64 cycles, led[1] for 128, led[2] for 255, and led[3] for 0.
REQ-030 Prescaler: write PRESC=3 -> pwm_cnt advances exactly once every 4 cycles (checked via STATUS reads); rewriting PRESC=3 mid-count restarts the 4-cycle spacing from that write.
REQ-031 Wrap flag: with PRESC=0, wait ≥256 cycles -> STATUS bit8=1; write STATUS -> bit8=0; a STATUS write timed on the 255->0 edge -> bit8 reads 1.
REQ-032 Reset mid-operation: with PWM running at PRESC=2 and pwm_cnt≈100, pulse reset for 1 cycle -> led=0, rdata=0, and all registers read 0; pwm_cnt then counts 0,1,2,... one per cycle.
REQ-033 Bus corners: read of STATUS simultaneous with tick returns the pre-edge pwm_cnt; a write with sel=0 changes no register; CTRL write 0xFFFF_FFFF reads back 0x0000_00FF.
